// File: rtl/pb_pkg.sv
// rtl/pb_pkg.sv - shared constants and event type for the pushbutton event generator
package pb_pkg;

  localparam int NB_DEFAULT    = 6;
  localparam int CLK_HZ        = 50_000_000;
  localparam int DEBOUNCE_10MS = CLK_HZ / 100;
  localparam int REPEAT_500MS  = CLK_HZ / 2;
  localparam int REPEAT_100MS  = CLK_HZ / 10;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_PRESS,
    EV_RELEASE
  } pb_ev_e;

endpackage

// File: rtl/pb_event_gen_if.sv
// rtl/pb_event_gen_if.sv - raw pushbutton inputs and debounced event outputs
interface pb_event_gen_if
  import pb_pkg::*;
#(
  parameter int NB = NB_DEFAULT
);

  logic [NB-1:0] PB;       // raw, active-low
  logic [NB-1:0] PRESS;    // one-cycle press events
  logic [NB-1:0] RELEASE;  // one-cycle release events
  logic [NB-1:0] LEVEL;    // debounced state, 1 = held

  modport master (input PB, output PRESS, output RELEASE, output LEVEL);
  modport slave  (output PB, input PRESS, input RELEASE, input LEVEL);

endinterface

// File: rtl/pb_debounce_bit.sv
// rtl/pb_debounce_bit.sv - one button: synchronizer, debounce, events; auto-repeat under PB_AUTOREPEAT_EN
module pb_debounce_bit
  import pb_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int REPEAT_DELAY    = REPEAT_500MS,
  parameter int REPEAT_PERIOD   = REPEAT_100MS
) (
  input  logic CLK,
  input  logic RST,
  input  logic pb_raw_n,
  output logic press_pulse,
  output logic release_pulse,
  output logic level
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("pb_debounce_bit: invalid timing parameters");
  end

  logic          sync1;
  logic          sync2;
  logic          stable;   // 1 = pressed
  logic [CW-1:0] cnt;
  pb_ev_e        ev;
  logic          mismatch;
  logic          toggle;

  // sync2 is active-low, stable is active-high, so equality means disagreement
  assign mismatch = (sync2 == stable);
  assign toggle   = mismatch && (cnt == CNT_LAST);

  // synchronize the raw input, count stable disagreement, accept new level and flag the event
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      stable <= 1'b0;
      cnt    <= '0;
      ev     <= EV_NONE;
    end else begin
      sync1 <= pb_raw_n;
      sync2 <= sync1;
      ev    <= EV_NONE;
      if (!mismatch) begin
        cnt <= '0;
      end else if (toggle) begin
        cnt    <= '0;
        stable <= ~stable;
        ev     <= stable ? EV_RELEASE : EV_PRESS;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level         = stable;
  assign release_pulse = (ev == EV_RELEASE);

`ifdef PB_AUTOREPEAT_EN
  localparam int            RW          = $clog2((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) + 1;
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_first;
  logic          rpt_pulse;

  // repeat timer runs while held; the release edge itself never fires a repeat
  always_ff @(posedge CLK) begin
    if (RST) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
      rpt_pulse <= 1'b0;
    end else begin
      rpt_pulse <= 1'b0;
      if (!stable || toggle) begin
        rpt_cnt   <= '0;
        rpt_first <= 1'b1;
      end else if (rpt_cnt == (rpt_first ? DELAY_LAST : PERIOD_LAST)) begin
        rpt_cnt   <= '0;
        rpt_first <= 1'b0;
        rpt_pulse <= 1'b1;
      end else begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end
    end
  end

  assign press_pulse = (ev == EV_PRESS) | rpt_pulse;
`else
  assign press_pulse = (ev == EV_PRESS);
`endif

endmodule

// File: rtl/pb_event_gen.sv
// rtl/pb_event_gen.sv - NB independent pushbutton debouncers; auto-repeat under PB_AUTOREPEAT_EN
module pb_event_gen
  import pb_pkg::*;
#(
  parameter int NB              = NB_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int REPEAT_DELAY    = REPEAT_500MS,
  parameter int REPEAT_PERIOD   = REPEAT_100MS
) (
  input  logic           CLK,
  input  logic           RST,
  pb_event_gen_if.master pb_if
);

  // one independent debouncer per button
  for (genvar i = 0; i < NB; i++) begin : g_bit
    pb_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_bit (
      .CLK           (CLK),
      .RST           (RST),
      .pb_raw_n      (pb_if.PB[i]),
      .press_pulse   (pb_if.PRESS[i]),
      .release_pulse (pb_if.RELEASE[i]),
      .level         (pb_if.LEVEL[i])
    );
  end

endmodule

// File: doc/pb_event_gen.md
# pb_event_gen

Converts raw, active-low, bouncing pushbutton inputs into clean, synchronous, single-cycle press events and debounced levels. It sits between the board pushbuttons and the scoreboard controller. The controller therefore sees exactly one increment or decrement command per physical press, not one per enabled tick while the button is held. All buttons are handled independently and in parallel.

## Interface
Parameters:
- NB, 6, number of pushbuttons.
- DEBOUNCE_CYCLES, 500_000, consecutive stable clocks needed to accept a new level (10 ms at 50 MHz). Must be ≥ 2.
- REPEAT_DELAY, 25_000_000, clocks from the initial press event to the first auto-repeat event. Used only with PB_AUTOREPEAT_EN.
- REPEAT_PERIOD, 5_000_000, clocks between subsequent auto-repeat events. Used only with PB_AUTOREPEAT_EN.

Ports:
- CLK  input  1  system clock, 50 MHz; all logic on posedge.
- RST  input  1  reset; one clock; synchronous, active-high.
- PB  input  NB  raw pushbuttons, active-low (0 = pressed), asynchronous to CLK.
- PRESS  output  NB  one-cycle active-high press event per button.
- RELEASE  output  NB  one-cycle active-high release event per button.
- LEVEL  output  NB  debounced state, active-high (1 = held).

## Operation
- Per button: 2-flop synchronizer, then a debounce counter, a stable-state register, and edge/event logic.
- Synchronizer flops reset to 1 (released).
- Debounce rule:
  - If sync output ≠ stable state, the counter increments.
  - If they are equal, the counter clears to 0.
  - When the counter equals DEBOUNCE_CYCLES-1 and a mismatch is still present, the stable state toggles and the counter clears.
- Glitches shorter than DEBOUNCE_CYCLES clocks produce no event and leave LEVEL unchanged.
- PRESS[i] pulses in the cycle after stable[i] goes 0→1 (pressed). RELEASE[i] pulses in the cycle after stable[i] goes 1→0.
- LEVEL = stable state (registered).
- Counter width is $clog2(DEBOUNCE_CYCLES). The counter never wraps; it clears on toggle or match.
- Buttons are independent. Any combination of PRESS/RELEASE bits may be high in the same cycle.
- A press and a release are never reported on the same bit in the same cycle.
- Reset values: PRESS=0, RELEASE=0, LEVEL=0, all counters 0, stable state = released.
- Reset mid-debounce abandons the pending transition.
- A button held through reset is reported as a fresh press after reset deasserts plus the normal latency.

## Timing
- Let edge k be the first posedge that samples a new raw level into sync stage 1.
  - Sync stage 2 holds the new level after edge k+1.
  - Mismatch is counted on edges k+2 … k+DEBOUNCE_CYCLES+1.
  - Stable toggles at edge k+DEBOUNCE_CYCLES+1.
  - PRESS/RELEASE are high for exactly the one cycle following that edge. LEVEL changes at the same edge.
- Total latency: DEBOUNCE_CYCLES+2 clocks from edge k to the event being visible, with no combinational input-to-output path.
- Minimum separation between successive events on one bit: DEBOUNCE_CYCLES clocks.

## Configuration
- PB_AUTOREPEAT_EN defined:
  - While LEVEL[i]=1, a per-button repeat counter runs.
  - An extra PRESS[i] pulse fires REPEAT_DELAY clocks after the initial PRESS[i], then every REPEAT_PERIOD clocks while the button stays held.
  - The repeat counter clears on release and on RST.
  - RELEASE behaviour is unchanged.
- PB_AUTOREPEAT_EN undefined:
  - Exactly one PRESS per debounced press.
  - Repeat counters and the REPEAT_* parameters are not synthesized.

## Structure
- Shared package pb_pkg holds:
  - NB_DEFAULT = 6
  - CLK_HZ = 50_000_000
  - DEBOUNCE_10MS = 500_000
  - REPEAT_500MS and REPEAT_100MS constants
  - an event-type enum {EV_NONE, EV_PRESS, EV_RELEASE}
- Natural sub-module: pb_debounce_bit. It contains the synchronizer, debounce counter, stable register, event pulses and optional repeat logic for one button. The top module instantiates it NB times in a generate loop.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Reset, PB=all 1 for 20 clocks -> PRESS=RELEASE=LEVEL=0 throughout.
- PB[0] driven 1→0 and held -> PRESS[0] high for exactly 1 cycle, 6 clocks after the first sampling edge; LEVEL[0]=1 from that cycle on; no other bits active.
- PB[1] low for 3 clocks, then high (glitch) -> no PRESS[1], LEVEL[1] stays 0. Repeat as a bounce train 0,1,0,1 then steady 0 -> exactly one PRESS[1] after the steady level persists 4 counted clocks.
- PB[2] and PB[3] pressed on the same clock, later released on the same clock -> PRESS[3:2]=2'b11 in the same cycle; later RELEASE[3:2]=2'b11 in the same cycle.
- PB[0] held, RST asserted for 1 clock mid-hold -> all outputs 0 the cycle after RST. With PB[0] still low, a new PRESS[0] arrives 6 clocks after reset deasserts.
- With PB_AUTOREPEAT_EN, hold PB[4] -> initial PRESS[4], repeats 10 clocks later, then every 3 clocks. Release -> repeats stop, one RELEASE[4]. Without the macro -> single PRESS[4] only.
